reg_file_arbiter: RTL and testbench

Two-port access arbiter that shares a single-port register file (one synchronous-read/write port, `DATA_W` wide) between requesters A and B. It accepts read or write requests from each requester and grants them with round-robin priority. It sequences one register-file access at a time and returns read data with a one-cycle valid pulse. It sits directly in front of the register file; requesters never drive the register file themselves.

---
 rtl/reg_file_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_file_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file between
// requesters A and B; one access at a time, read data via rvalid pulse.
module reg_file_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rf_we,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // prio/owner/win: 0 selects A, 1 selects B
    logic              prio;
    logic              owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              any_req;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              take;

    assign any_req   = a_req | b_req;
    assign win       = (a_req & b_req) ? prio : ~a_req;
    assign sel_we    = win ? b_we    : a_we;
    assign sel_addr  = win ? b_addr  : a_addr;
    assign sel_wdata = win ? b_wdata : a_wdata;
    assign take      = (state == IDLE) & any_req;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take) begin
            prio      <= ~win;
            owner     <= win;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_we ? sel_wdata : '0;
        end
    end

    // rvalid is a single-cycle pulse overlapping the following IDLE
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rdata    <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (state == RESP) begin
                rdata    <= rf_rdata;
                a_rvalid <= ~owner;
                b_rvalid <= owner;
            end
        end
    end

    always_comb begin
        state_nx = state;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        rf_we    = 1'b0;
        rf_re    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nx = sel_we ? WRITE : READ;
                end
            end
            WRITE: begin
                rf_we    = 1'b1;
                rf_addr  = lat_addr;
                rf_wdata = lat_wdata;
                a_gnt    = ~owner;
                b_gnt    = owner;
                state_nx = IDLE;
            end
            READ: begin
                rf_re    = 1'b1;
                rf_addr  = lat_addr;
                a_gnt    = ~owner;
                b_gnt    = owner;
                state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level schedule model.
module tb_reg_file_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic          a_we = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic          rf_we, rf_re;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;
    logic          busy;
    logic          mem_clr = 1'b0;

    logic [DW-1:0] mem [32];
    logic [6:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .rf_we(rf_we), .rf_re(rf_re),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // flag order: a_gnt b_gnt rf_we rf_re a_rvalid b_rvalid busy
    assign flags = {a_gnt, b_gnt, rf_we, rf_re, a_rvalid, b_rvalid, busy};

    // behavioural single-port register file in front of which the DUT sits
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            rf_rdata <= '0;
        end else begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            if (rf_re) rf_rdata <= mem[rf_addr];
        end
    end

    task do_reset;
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0;
        a_wdata = '0; b_wdata = '0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
    endtask

    task test_reset;
        mem_clr = 1'b1;
        reset = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0 || rdata !== '0) begin
            n_bad++;
            $display("FAIL rst_hold: flags %b rdata %h want 0", flags, rdata);
        end
        @(negedge CLK);
        mem_clr = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({flags, rf_addr, rf_wdata, rdata} !== '0) begin
                n_bad++;
                $display("FAIL rst_idle: flags %b addr %h wd %h rd %h want 0",
                         flags, rf_addr, rf_wdata, rdata);
            end
        end
    endtask

    task test_random;
        logic [6:0]    e_flags [8];
        logic [AW-1:0] e_addr  [8];
        logic [DW-1:0] e_wdata [8];
        logic          e_ld    [8];
        logic [DW-1:0] e_rd    [8];
        logic [DW-1:0] mm [32];
        logic          m_prio, pend_a, pend_b, w, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd, m_rdata;
        int            idle_from, k;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            e_flags[i] = '0; e_addr[i] = '0; e_wdata[i] = '0;
            e_ld[i] = 1'b0; e_rd[i] = '0;
        end
        for (int i = 0; i < 32; i++) mm[i] = '0;
        m_prio = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
        m_rdata = '0; idle_from = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            k = c % 8;
            if (e_ld[k]) m_rdata = e_rd[k];
            n_cmp++;
            if (flags !== e_flags[k]) begin
                n_bad++;
                $display("FAIL rnd_flags c=%0d: got %b want %b", c, flags, e_flags[k]);
            end
            n_cmp++;
            if (rf_addr !== e_addr[k] || rf_wdata !== e_wdata[k]) begin
                n_bad++;
                $display("FAIL rnd_rf c=%0d: addr %h wd %h want %h %h",
                         c, rf_addr, rf_wdata, e_addr[k], e_wdata[k]);
            end
            n_cmp++;
            if (rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, m_rdata);
            end
            e_flags[k] = '0; e_addr[k] = '0; e_wdata[k] = '0; e_ld[k] = 1'b0;
            if (!pend_a && $urandom_range(0, 2) == 0) begin
                pend_a = 1'b1;
                a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom);
                a_wdata = $urandom;
            end
            if (!pend_b && $urandom_range(0, 2) == 0) begin
                pend_b = 1'b1;
                b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom);
                b_wdata = $urandom;
            end
            a_req = pend_a;
            b_req = pend_b;
            if (c >= idle_from && (pend_a || pend_b)) begin
                w  = (pend_a && pend_b) ? m_prio : pend_b;
                we = w ? b_we : a_we;
                ad = w ? b_addr : a_addr;
                wd = w ? b_wdata : a_wdata;
                e_flags[(c+1)%8] = {~w, w, we, ~we, 1'b0, 1'b0, 1'b1};
                e_addr[(c+1)%8]  = ad;
                e_wdata[(c+1)%8] = we ? wd : '0;
                if (we) begin
                    mm[ad] = wd;
                    idle_from = c + 2;
                end else begin
                    e_flags[(c+2)%8] = 7'b0000001;
                    e_flags[(c+3)%8] = {4'b0, ~w, w, 1'b0};
                    e_ld[(c+3)%8] = 1'b1;
                    e_rd[(c+3)%8] = mm[ad];
                    idle_from = c + 3;
                end
                m_prio = ~w;
                if (w) pend_b = 1'b0;
                else pend_a = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task test_write_read;
        do_reset;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 32'hAB;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b1010001 || rf_addr !== 5'd3 || rf_wdata !== 32'hAB) begin
            n_bad++;
            $display("FAIL wr_cycle: flags %b addr %h wd %h want 1010001 03 ab",
                     flags, rf_addr, rf_wdata);
        end
        a_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0) begin
            n_bad++;
            $display("FAIL wr_idle: flags %b want 0", flags);
        end
        a_req = 1'b1; a_we = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b1001001 || rf_addr !== 5'd3 || rf_wdata !== '0) begin
            n_bad++;
            $display("FAIL rd_cycle: flags %b addr %h wd %h want 1001001 03 0",
                     flags, rf_addr, rf_wdata);
        end
        a_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0000001) begin
            n_bad++;
            $display("FAIL rd_resp: flags %b want 0000001", flags);
        end
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0000100 || rdata !== 32'hAB) begin
            n_bad++;
            $display("FAIL rd_valid: flags %b rdata %h want 0000100 ab", flags, rdata);
        end
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0 || rdata !== 32'hAB) begin
            n_bad++;
            $display("FAIL rd_hold: flags %b rdata %h want 0 ab", flags, rdata);
        end
    endtask

    task test_contention;
        int na, nb;
        logic [1:0] eg;
        logic [AW-1:0] ea;
        do_reset;
        na = 0; nb = 0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 32'hA1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd2; b_wdata = 32'hB2;
        for (int i = 0; i < 8; i++) begin
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            ea = (i % 2 == 0) ? 5'd1 : 5'd2;
            @(negedge CLK);
            n_cmp++;
            if ({a_gnt, b_gnt} !== eg || rf_we !== 1'b1 || rf_addr !== ea) begin
                n_bad++;
                $display("FAIL cont_gnt%0d: gnt %b we %b addr %h want %b 1 %h",
                         i, {a_gnt, b_gnt}, rf_we, rf_addr, eg, ea);
            end
            if (i % 2 == 0) na++;
            else nb++;
            if (na == 4) a_req = 1'b0;
            if (nb == 4) b_req = 1'b0;
            @(negedge CLK);
            n_cmp++;
            if (flags !== 7'b0) begin
                n_bad++;
                $display("FAIL cont_gap%0d: flags %b want 0", i, flags);
            end
        end
    endtask

    task test_prio;
        do_reset;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 32'h77;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0110001 || rf_addr !== 5'd7) begin
            n_bad++;
            $display("FAIL prio_b: flags %b addr %h want 0110001 07", flags, rf_addr);
        end
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd6; a_wdata = 32'h66;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({a_gnt, b_gnt} !== 2'b10 || rf_addr !== 5'd6) begin
            n_bad++;
            $display("FAIL prio_a: gnt %b addr %h want 10 06", {a_gnt, b_gnt}, rf_addr);
        end
        a_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({a_gnt, b_gnt} !== 2'b01 || rf_addr !== 5'd7) begin
            n_bad++;
            $display("FAIL prio_b2: gnt %b addr %h want 01 07", {a_gnt, b_gnt}, rf_addr);
        end
        b_req = 1'b0;
        @(negedge CLK);
    endtask

    task test_mixed;
        do_reset;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 32'h1234_5678;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b1010001 || rf_wdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mix_wr: flags %b wd %h want 1010001 12345678", flags, rf_wdata);
        end
        a_req = 1'b0;
        @(negedge CLK);
        a_req = 1'b1; a_we = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b1001001 || rf_addr !== 5'd5) begin
            n_bad++;
            $display("FAIL mix_rd: flags %b addr %h want 1001001 05", flags, rf_addr);
        end
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd9; b_wdata = $urandom;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0000001) begin
            n_bad++;
            $display("FAIL mix_resp: flags %b want 0000001", flags);
        end
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0000100 || rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mix_rv: flags %b rdata %h want 0000100 12345678", flags, rdata);
        end
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0110001 || rf_addr !== 5'd9 || rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mix_bwr: flags %b addr %h rdata %h want 0110001 09 12345678",
                     flags, rf_addr, rdata);
        end
        b_req = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0 || rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mix_hold: flags %b rdata %h want 0 12345678", flags, rdata);
        end
    endtask

    task test_reset_mid_read;
        do_reset;
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        @(negedge CLK);
        a_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b0000100 || rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mid_pre: flags %b rdata %h want 0000100 12345678", flags, rdata);
        end
        a_req = 1'b1; a_addr = 5'd3;
        @(negedge CLK);
        n_cmp++;
        if (flags !== 7'b1001001 || rf_addr !== 5'd3) begin
            n_bad++;
            $display("FAIL mid_rd: flags %b addr %h want 1001001 03", flags, rf_addr);
        end
        a_req = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 7'b0 || rdata !== '0) begin
            n_bad++;
            $display("FAIL mid_abort: flags %b rdata %h want 0 0", flags, rdata);
        end
        @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (flags !== 7'b0 || rdata !== '0) begin
                n_bad++;
                $display("FAIL mid_after%0d: flags %b rdata %h want 0 0", i, flags, rdata);
            end
        end
    endtask

    initial begin
        test_reset;
        test_random;
        test_write_read;
        test_contention;
        test_prio;
        test_mixed;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
